mont_seq_ctrl: RTL and testbench

Sequencing controller for the Montgomery multiplier's operand/result buffers. Accepts 32-bit host word writes and steers them into three 32-word operand buffers (A, B, M), tracks which operands are fully loaded, and starts the core. It waits for completion, then strobes the wide write port of the result buffer and reports done to the host. It sits between the AXI-side register interface and the word-port/wide-port buffer RAMs.

---
 rtl/mont_pkg.sv | 24 ++
 rtl/mont_addr_check.sv | 31 +++
 rtl/mont_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_mont_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery multiplier sequencing logic.
package mont_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned OP_A = 0;
  localparam int unsigned OP_B = 1;
  localparam int unsigned OP_M = 2;

  localparam int unsigned DEFAULT_WORD_COUNT = 32;

  function automatic int unsigned last_word_addr(input int unsigned word_count);
    return (word_count - 1) * 4;
  endfunction

  localparam int unsigned LAST_WORD_ADDR = last_word_addr(DEFAULT_WORD_COUNT);

endpackage

// File: rtl/mont_addr_check.sv
// Combinational legality check for a host word access: buffer select,
// word alignment and range, plus detection of the final word address.
module mont_addr_check
  import mont_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned WORD_COUNT = 32
) (
  input  logic [1:0]        sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              legal_o,
  output logic              last_o
);

  // One extra bit so the exclusive limit fits even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(WORD_COUNT * 4);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(last_word_addr(WORD_COUNT));

  logic sel_ok;
  logic align_ok;
  logic range_ok;

  always_comb begin
    sel_ok   = (sel_i != 2'd3);
    align_ok = (addr_i[1:0] == 2'b00);
    range_ok = ({1'b0, addr_i} < ADDR_LIMIT);
    legal_o  = sel_ok && align_ok && range_ok;
    last_o   = (addr_i == ADDR_LAST);
  end

endmodule

// File: rtl/mont_seq_ctrl.sv
// Sequencing controller: steers host words into the A/B/M operand buffers,
// starts the Montgomery core and hands its result to the result buffer.
module mont_seq_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = 10,
  parameter int unsigned BRAM_WORD_COUNT = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       host_we,
  input  logic [1:0]                 host_sel,
  input  logic [BRAM_ADDR_WIDTH-1:0] host_addr,
  input  logic [31:0]                host_wdata,
  input  logic                       host_start,
  output logic                       host_busy,
  output logic                       host_done,
  output logic                       host_err,
  output logic [2:0]                 loaded,
  output logic [31:0]                cycle_count,
  output logic [2:0]                 buf_we,
  output logic [BRAM_ADDR_WIDTH-1:0] buf_addr,
  output logic [31:0]                buf_data,
  output logic                       core_start,
  input  logic                       core_done,
  output logic                       res_web,
  input  logic                       res_dinb_read,
  output logic [2:0]                 state_dbg
);

  state_e                     state_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       err_q;
  logic [2:0]                 loaded_q;
  logic [31:0]                cnt_q;
  logic [31:0]                cnt_d;
  logic [2:0]                 buf_we_q;
  logic [BRAM_ADDR_WIDTH-1:0] buf_addr_q;
  logic [31:0]                buf_data_q;
  logic                       core_start_q;
  logic                       res_web_q;

  logic       addr_legal;
  logic       addr_last;
  logic       wr_ok;
  logic       start_ok;
  logic [2:0] sel_onehot;

  mont_addr_check #(
    .ADDR_W     (BRAM_ADDR_WIDTH),
    .WORD_COUNT (BRAM_WORD_COUNT)
  ) u_addr_check (
    .sel_i   (host_sel),
    .addr_i  (host_addr),
    .legal_o (addr_legal),
    .last_o  (addr_last)
  );

  // Start looks at the flags before any same-cycle write lands.
  always_comb begin
    wr_ok      = host_we && addr_legal && (state_q == ST_IDLE);
    start_ok   = host_start && (state_q == ST_IDLE) && (loaded_q == 3'b111);
    sel_onehot = 3'(3'b001 << host_sel);
    cnt_d      = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      loaded_q     <= 3'b000;
      cnt_q        <= 32'd0;
      buf_we_q     <= 3'b000;
      buf_addr_q   <= '0;
      buf_data_q   <= 32'd0;
      core_start_q <= 1'b0;
      res_web_q    <= 1'b0;
    end else begin
      buf_we_q     <= 3'b000;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= (host_we && !wr_ok) || (host_start && !start_ok);
      unique case (state_q)
        ST_IDLE: begin
          if (wr_ok) begin
            buf_we_q   <= sel_onehot;
            buf_addr_q <= host_addr;
            buf_data_q <= host_wdata;
            if (addr_last) loaded_q <= loaded_q | sel_onehot;
          end
          if (start_ok) begin
            state_q      <= ST_START;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            cnt_q        <= 32'd0;
          end
        end
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (core_done) begin
            state_q   <= ST_STORE;
            res_web_q <= 1'b1;
          end
        end
        ST_STORE: begin
          if (res_dinb_read) begin
            state_q   <= ST_DONE;
            res_web_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            loaded_q  <= 3'b000;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign host_busy   = busy_q;
  assign host_done   = done_q;
  assign host_err    = err_q;
  assign loaded      = loaded_q;
  assign cycle_count = cnt_q;
  assign buf_we      = buf_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_data    = buf_data_q;
  assign core_start  = core_start_q;
  assign res_web     = res_web_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mont_seq_ctrl.sv
// Directed bench for mont_seq_ctrl: operand loading, illegal accesses,
// start gating, a full run with cycle counting, and reset in mid-operation.
module tb_mont_seq_ctrl;

  localparam int AW = 10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          host_we;
  logic [1:0]    host_sel;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic          host_start;
  logic          host_busy;
  logic          host_done;
  logic          host_err;
  logic [2:0]    loaded;
  logic [31:0]   cycle_count;
  logic [2:0]    buf_we;
  logic [AW-1:0] buf_addr;
  logic [31:0]   buf_data;
  logic          core_start;
  logic          core_done;
  logic          res_web;
  logic          res_dinb_read;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  mont_seq_ctrl #(
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_WORD_COUNT (32)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .host_we       (host_we),
    .host_sel      (host_sel),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_start    (host_start),
    .host_busy     (host_busy),
    .host_done     (host_done),
    .host_err      (host_err),
    .loaded        (loaded),
    .cycle_count   (cycle_count),
    .buf_we        (buf_we),
    .buf_addr      (buf_addr),
    .buf_data      (buf_data),
    .core_start    (core_start),
    .core_done     (core_done),
    .res_web       (res_web),
    .res_dinb_read (res_dinb_read),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_data(input logic [1:0] sel, input int i);
    return 32'hA000_0000 + {6'h0, sel, 24'h0} + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Back-to-back load of all 32 words; optionally raise host_start with the last one.
  task automatic load_buf(input logic [1:0] sel, input logic start_on_last,
                          input logic [2:0] exp_loaded);
    for (int i = 0; i < 32; i++) begin
      host_we    = 1'b1;
      host_sel   = sel;
      host_addr  = AW'(i * 4);
      host_wdata = word_data(sel, i);
      host_start = (i == 31) ? start_on_last : 1'b0;
      tick();
      chk("buf_we", 32'(buf_we), 32'(onehot(sel)));
      chk("buf_addr", 32'(buf_addr), 32'(i * 4));
      chk("buf_data", buf_data, word_data(sel, i));
      if (i == 31) begin
        chk("loaded_after_last", 32'(loaded), 32'(exp_loaded));
        chk("err_on_last", 32'(host_err), 32'(start_on_last));
        chk("core_start_on_last", 32'(core_start), 32'd0);
        chk("state_on_last", 32'(state_dbg), 32'(S_IDLE));
      end
    end
    host_we    = 1'b0;
    host_start = 1'b0;
    tick();
    chk("buf_we_single", 32'(buf_we), 32'd0);
    chk("err_clear_after_load", 32'(host_err), 32'd0);
  endtask

  task automatic bad_write(input string tag, input logic [1:0] sel, input logic [AW-1:0] addr);
    host_we    = 1'b1;
    host_sel   = sel;
    host_addr  = addr;
    host_wdata = 32'hDEAD_BEEF;
    tick();
    host_we = 1'b0;
    chk({tag, "_err"}, 32'(host_err), 32'd1);
    chk({tag, "_buf_we"}, 32'(buf_we), 32'd0);
    chk({tag, "_loaded"}, 32'(loaded), 32'h7);
    tick();
    chk({tag, "_err_pulse"}, 32'(host_err), 32'd0);
  endtask

  // Full operation: waitc cycles in WAIT (core_done in the last), read ack
  // rdly cycles after res_web rises. Illegal requests are injected while busy.
  task automatic run_op(input int waitc, input int rdly);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("core_start", 32'(core_start), 32'd1);
    chk("busy_on_start", 32'(host_busy), 32'd1);
    chk("state_start", 32'(state_dbg), 32'(S_START));
    chk("err_on_good_start", 32'(host_err), 32'd0);
    tick();
    chk("core_start_single", 32'(core_start), 32'd0);
    chk("state_wait", 32'(state_dbg), 32'(S_WAIT));
    chk("count_cleared", cycle_count, 32'd0);
    for (int i = 1; i < waitc; i++) begin
      if (i == 2) begin
        host_we   = 1'b1;
        host_sel  = 2'd0;
        host_addr = '0;
      end
      if (i == 3) host_start = 1'b1;
      tick();
      if (i == 2 || i == 3) begin
        chk("err_while_busy", 32'(host_err), 32'd1);
        chk("buf_we_while_busy", 32'(buf_we), 32'd0);
        chk("state_still_wait", 32'(state_dbg), 32'(S_WAIT));
      end
      host_we    = 1'b0;
      host_start = 1'b0;
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("state_store", 32'(state_dbg), 32'(S_STORE));
    chk("res_web_rise", 32'(res_web), 32'd1);
    chk("cycle_count", cycle_count, 32'(waitc));
    chk("busy_in_store", 32'(host_busy), 32'd1);
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("res_web_held", 32'(res_web), 32'd1);
      chk("done_low_in_store", 32'(host_done), 32'd0);
    end
    res_dinb_read = 1'b1;
    tick();
    res_dinb_read = 1'b0;
    chk("res_web_fall", 32'(res_web), 32'd0);
    chk("host_done", 32'(host_done), 32'd1);
    chk("busy_fall", 32'(host_busy), 32'd0);
    chk("loaded_cleared", 32'(loaded), 32'd0);
    chk("state_done", 32'(state_dbg), 32'(S_DONE));
    chk("cycle_count_hold", cycle_count, 32'(waitc));
    tick();
    chk("host_done_single", 32'(host_done), 32'd0);
    chk("state_back_idle", 32'(state_dbg), 32'(S_IDLE));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_buf_we"}, 32'(buf_we), 32'd0);
    chk({tag, "_buf_addr"}, 32'(buf_addr), 32'd0);
    chk({tag, "_buf_data"}, buf_data, 32'd0);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_res_web"}, 32'(res_web), 32'd0);
    chk({tag, "_busy"}, 32'(host_busy), 32'd0);
    chk({tag, "_done"}, 32'(host_done), 32'd0);
    chk({tag, "_err"}, 32'(host_err), 32'd0);
    chk({tag, "_loaded"}, 32'(loaded), 32'd0);
    chk({tag, "_count"}, cycle_count, 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  initial begin
    resetn        = 1'b0;
    host_we       = 1'b0;
    host_sel      = 2'd0;
    host_addr     = '0;
    host_wdata    = 32'd0;
    host_start    = 1'b0;
    core_done     = 1'b0;
    res_dinb_read = 1'b0;

    tick();
    tick();
    check_all_zero("reset");
    resetn = 1'b1;
    tick();
    check_all_zero("post_reset");

    load_buf(2'd0, 1'b0, 3'b001);
    load_buf(2'd1, 1'b0, 3'b011);

    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk("partial_start_err", 32'(host_err), 32'd1);
    chk("partial_start_no_core", 32'(core_start), 32'd0);
    chk("partial_start_idle", 32'(state_dbg), 32'(S_IDLE));
    chk("partial_start_busy", 32'(host_busy), 32'd0);

    load_buf(2'd2, 1'b1, 3'b111);

    bad_write("misaligned_82", 2'd0, 10'h082);
    bad_write("range_80", 2'd1, 10'h080);
    bad_write("sel3", 2'd3, 10'h000);
    chk("buf_addr_unchanged", 32'(buf_addr), 32'h7C);

    host_we    = 1'b1;
    host_sel   = 2'd0;
    host_addr  = 10'h010;
    host_wdata = 32'h1234_5678;
    tick();
    host_we = 1'b0;
    chk("rewrite_buf_we", 32'(buf_we), 32'h1);
    chk("rewrite_keeps_loaded", 32'(loaded), 32'h7);

    core_done     = 1'b1;
    res_dinb_read = 1'b1;
    tick();
    core_done     = 1'b0;
    res_dinb_read = 1'b0;
    chk("stray_done_idle", 32'(state_dbg), 32'(S_IDLE));
    chk("stray_done_res_web", 32'(res_web), 32'd0);

    run_op(100, 2);

    load_buf(2'd0, 1'b0, 3'b001);
    load_buf(2'd1, 1'b0, 3'b011);
    load_buf(2'd2, 1'b0, 3'b111);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk("pre_reset_store", 32'(state_dbg), 32'(S_STORE));
    chk("pre_reset_res_web", 32'(res_web), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick();
    resetn = 1'b1;
    tick();
    check_all_zero("after_async_reset");

    load_buf(2'd0, 1'b0, 3'b001);
    load_buf(2'd1, 1'b0, 3'b011);
    load_buf(2'd2, 1'b0, 3'b111);
    run_op(5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
